// File: rtl/axi_b_resp_gen_if.sv
// AW/write-completion/B-FIFO signal bundle for axi_b_resp_gen.
// slave = the response generator, master = the surrounding logic that drives it.
interface axi_b_resp_gen_if #(
    parameter int IdWidth   = 4,
    parameter int UserWidth = 1,
    parameter int LenWidth  = 8
);
    localparam int BWidth = IdWidth + 2 + UserWidth;

    logic                 aw_valid_i;
    logic                 aw_ready_o;
    logic [IdWidth-1:0]   aw_id_i;
    logic [LenWidth-1:0]  aw_len_i;
    logic [UserWidth-1:0] aw_user_i;
    logic                 wr_done_i;
    logic                 wr_err_i;
    logic                 wr_decerr_i;
    logic [BWidth-1:0]    b_data_o;
    logic                 b_push_o;
    logic                 b_full_i;
    logic                 stray_o;
    logic [15:0]          bursts_o;

    modport slave (
        input  aw_valid_i, aw_id_i, aw_len_i, aw_user_i,
        input  wr_done_i, wr_err_i, wr_decerr_i, b_full_i,
        output aw_ready_o, b_data_o, b_push_o, stray_o, bursts_o
    );

    modport master (
        output aw_valid_i, aw_id_i, aw_len_i, aw_user_i,
        output wr_done_i, wr_err_i, wr_decerr_i, b_full_i,
        input  aw_ready_o, b_data_o, b_push_o, stray_o, bursts_o
    );
endinterface

// File: rtl/axi_b_resp_gen.sv
// AXI write-response generator: one B record {id, resp, user} per AW burst, pushed to the B FIFO.
// Optional macro AXI_B_RESP_DECERR_EN: wr_decerr_i contributes DECERR (11) with priority over SLVERR.
module axi_b_resp_gen #(
    parameter int IdWidth   = 4,
    parameter int UserWidth = 1,
    parameter int LenWidth  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    axi_b_resp_gen_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_PUSH  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [LenWidth-1:0]  r_beat_cnt;
    logic [1:0]           r_resp;
    logic [IdWidth-1:0]   r_id;
    logic [UserWidth-1:0] r_user;
    logic [15:0]          r_bursts;

    logic                 w_aw_ready;
    logic                 w_aw_fire;
    logic                 w_beat;
    logic                 w_push;
    logic                 w_stray;
    logic [1:0]           w_beat_code;

    // Codes are ordered OKAY(00) < SLVERR(10) < DECERR(11), so merging is a numeric max.
`ifdef AXI_B_RESP_DECERR_EN
    assign w_beat_code = bus.wr_decerr_i ? 2'b11 : (bus.wr_err_i ? 2'b10 : 2'b00);
`else
    logic w_unused_decerr;
    assign w_unused_decerr = bus.wr_decerr_i;
    assign w_beat_code     = bus.wr_err_i ? 2'b10 : 2'b00;
`endif

    always_comb begin
        w_state_next = r_state;
        w_aw_ready   = 1'b0;
        w_aw_fire    = 1'b0;
        w_beat       = 1'b0;
        w_push       = 1'b0;
        w_stray      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_aw_ready = 1'b1;
                w_aw_fire  = bus.aw_valid_i;
                // A completion alongside the AW handshake belongs to no burst yet.
                w_stray    = bus.wr_done_i;
                if (w_aw_fire) begin
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                w_beat = bus.wr_done_i;
                if (w_beat && (r_beat_cnt == '0)) begin
                    w_state_next = S_PUSH;
                end
            end
            S_PUSH: begin
                w_push  = ~bus.b_full_i;
                w_stray = bus.wr_done_i;
                if (w_push) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Reset discards whatever is in flight, including a pending push.
        if (rst_i) begin
            w_aw_fire = 1'b0;
            w_beat    = 1'b0;
            w_push    = 1'b0;
            w_stray   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_beat_cnt <= '0;
            r_resp     <= 2'b00;
            r_id       <= '0;
            r_user     <= '0;
            r_bursts   <= 16'd0;
        end else begin
            if (w_aw_fire) begin
                r_id       <= bus.aw_id_i;
                r_user     <= bus.aw_user_i;
                r_resp     <= 2'b00;
                r_beat_cnt <= bus.aw_len_i;
            end else if (w_beat) begin
                if (w_beat_code > r_resp) begin
                    r_resp <= w_beat_code;
                end
                if (r_beat_cnt != '0) begin
                    r_beat_cnt <= r_beat_cnt - 1'b1;
                end
            end
            if (w_push) begin
                r_bursts <= r_bursts + 16'd1;
            end
        end
    end

    assign bus.aw_ready_o = w_aw_ready;
    assign bus.b_push_o   = w_push;
    assign bus.stray_o    = w_stray;
    assign bus.bursts_o   = r_bursts;
    assign bus.b_data_o   = {r_id, r_resp, r_user};
endmodule

// File: tb/tb_axi_b_resp_gen.sv
// Bench for axi_b_resp_gen: burst-level reference model checked every cycle plus literal B records.
// Build with or without AXI_B_RESP_DECERR_EN; the decode-error expectation follows the macro.
module tb_axi_b_resp_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_b_resp_gen_if #(.IdWidth(4), .UserWidth(1), .LenWidth(8)) bus ();
    axi_b_resp_gen #(.IdWidth(4), .UserWidth(1), .LenWidth(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

`ifdef AXI_B_RESP_DECERR_EN
    localparam bit DecerrEn = 1'b1;
`else
    localparam bit DecerrEn = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Burst-level model: phase 0 = waiting for AW, 1 = collecting beats, 2 = record ready.
    int         m_phase = 0;
    int         m_left  = 0;
    logic [1:0] m_resp  = 2'b00;
    logic [3:0] m_id    = 4'h0;
    logic       m_user  = 1'b0;
    int         m_bursts = 0;
    logic [6:0] got_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [1:0] code;
        if (rst) begin
            m_phase  = 0;
            m_left   = 0;
            m_resp   = 2'b00;
            m_id     = 4'h0;
            m_user   = 1'b0;
            m_bursts = 0;
        end else begin
            case (m_phase)
                0: if (bus.aw_valid_i) begin
                    m_phase = 1;
                    m_left  = int'(bus.aw_len_i) + 1;
                    m_resp  = 2'b00;
                    m_id    = bus.aw_id_i;
                    m_user  = bus.aw_user_i;
                end
                1: if (bus.wr_done_i) begin
                    code = (DecerrEn && bus.wr_decerr_i) ? 2'b11 : (bus.wr_err_i ? 2'b10 : 2'b00);
                    if (code > m_resp) m_resp = code;
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (!bus.b_full_i) begin
                    m_bursts = (m_bursts + 1) % 65536;
                    m_phase  = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("aw_ready", {31'd0, bus.aw_ready_o}, {31'd0, m_phase == 0});
            check("b_push", {31'd0, bus.b_push_o}, {31'd0, (m_phase == 2) && !bus.b_full_i});
            check("stray", {31'd0, bus.stray_o}, {31'd0, bus.wr_done_i && (m_phase != 1)});
            check("bursts", {16'd0, bus.bursts_o}, m_bursts);
            check("b_data", {25'd0, bus.b_data_o}, {25'd0, m_id, m_resp, m_user});
            if (bus.b_push_o) begin
                got_q.push_back(bus.b_data_o);
                $display("push b_data=%02h bursts_before=%0d t=%0t", bus.b_data_o, bus.bursts_o, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input logic [3:0] id, input logic [7:0] len, input logic user);
        bus.aw_valid_i = 1'b1;
        bus.aw_id_i    = id;
        bus.aw_len_i   = len;
        bus.aw_user_i  = user;
        tick();
        bus.aw_valid_i = 1'b0;
    endtask

    task automatic beat(input logic err, input logic decerr);
        bus.wr_done_i   = 1'b1;
        bus.wr_err_i    = err;
        bus.wr_decerr_i = decerr;
        tick();
        bus.wr_done_i   = 1'b0;
        bus.wr_err_i    = 1'b0;
        bus.wr_decerr_i = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.aw_valid_i  = 1'b0;
        bus.aw_id_i     = 4'h0;
        bus.aw_len_i    = 8'h00;
        bus.aw_user_i   = 1'b0;
        bus.wr_done_i   = 1'b0;
        bus.wr_err_i    = 1'b0;
        bus.wr_decerr_i = 1'b0;
        bus.b_full_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_aw_ready", {31'd0, bus.aw_ready_o}, 32'd1);
        check("rst_b_push", {31'd0, bus.b_push_o}, 32'd0);
        check("rst_b_data", {25'd0, bus.b_data_o}, 32'd0);
        check("rst_bursts", {16'd0, bus.bursts_o}, 32'd0);
        check("rst_stray", {31'd0, bus.stray_o}, 32'd0);
        tick();

        // Single len=0 burst.
        aw(4'h3, 8'd0, 1'b1);
        beat(1'b0, 1'b0);
        tick();
        check("t1_npush", got_q.size(), 32'd1);
        check("t1_data", {25'd0, got_q[0]}, 32'h19);
        check("t1_bursts", {16'd0, bus.bursts_o}, 32'd1);

        // Error merge over four beats.
        aw(4'h5, 8'd3, 1'b0);
        beat(1'b0, 1'b0);
        tick();
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        check("t2_no_early_push", got_q.size(), 32'd1);
        tick();
        check("t2_npush", got_q.size(), 32'd2);
        check("t2_data", {25'd0, got_q[1]}, 32'h2C);

        // Backpressure for 5 cycles in PUSH.
        aw(4'h2, 8'd1, 1'b1);
        beat(1'b0, 1'b0);
        bus.b_full_i = 1'b1;
        beat(1'b0, 1'b0);
        repeat (5) tick();
        check("t3_held_npush", got_q.size(), 32'd2);
        check("t3_held_ready", {31'd0, bus.aw_ready_o}, 32'd0);
        check("t3_held_data", {25'd0, bus.b_data_o}, 32'h11);
        bus.b_full_i = 1'b0;
        tick();
        check("t3_npush", got_q.size(), 32'd3);
        check("t3_data", {25'd0, got_q[2]}, 32'h11);

        // Stray beats: in IDLE, with the AW handshake, and in PUSH.
        bus.wr_done_i = 1'b1;
        bus.wr_err_i  = 1'b1;
        bus.wr_decerr_i = 1'b1;
        #1;
        check("t4_stray_idle", {31'd0, bus.stray_o}, 32'd1);
        tick();
        bus.wr_done_i = 1'b0;
        bus.wr_err_i  = 1'b0;
        bus.wr_decerr_i = 1'b0;
        bus.wr_done_i = 1'b1;
        bus.wr_err_i  = 1'b1;
        aw(4'h1, 8'd0, 1'b1);
        bus.wr_done_i = 1'b0;
        bus.wr_err_i  = 1'b0;
        beat(1'b0, 1'b0);
        tick();
        check("t4_aw_stray_data", {25'd0, got_q[3]}, 32'h09);
        aw(4'h6, 8'd0, 1'b0);
        bus.b_full_i = 1'b1;
        beat(1'b0, 1'b0);
        bus.wr_done_i = 1'b1;
        bus.wr_err_i  = 1'b1;
        #1;
        check("t4_stray_push", {31'd0, bus.stray_o}, 32'd1);
        tick();
        bus.wr_done_i = 1'b0;
        bus.wr_err_i  = 1'b0;
        bus.b_full_i  = 1'b0;
        tick();
        check("t4_data", {25'd0, got_q[4]}, 32'h30);
        check("t4_bursts", {16'd0, bus.bursts_o}, 32'd5);

        // Maximum length: 256 beats, error on the last one.
        aw(4'h9, 8'd255, 1'b0);
        for (int i = 1; i <= 256; i++) begin
            beat(i == 256, 1'b0);
        end
        check("t5_no_early_push", got_q.size(), 32'd5);
        tick();
        check("t5_npush", got_q.size(), 32'd6);
        check("t5_data", {25'd0, got_q[5]}, 32'h4C);

        // Reset after beat 100 of a max-length burst.
        aw(4'h9, 8'd255, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            beat(1'b0, 1'b0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_ready", {31'd0, bus.aw_ready_o}, 32'd1);
        check("t5_rst_push", {31'd0, bus.b_push_o}, 32'd0);
        check("t5_rst_bursts", {16'd0, bus.bursts_o}, 32'd0);
        repeat (3) tick();
        check("t5_rst_npush", got_q.size(), 32'd6);

        // Slave error then decode error.
        aw(4'h4, 8'd1, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        tick();
        check("t6_npush", got_q.size(), 32'd7);
        check("t6_data", {25'd0, got_q[6]}, DecerrEn ? 32'h27 : 32'h25);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
